// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_t;

   localparam int M_CORE = 0;
   localparam int M_AUX  = 1;

   // Wide enough to hold RD_LAT-1 for the largest supported latency (7).
   localparam int CNT_W = 3;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; on contention the
// requester that did not win last time is chosen.
module rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_enable,
   output logic [1:0] o_gnt,
   output logic       o_winner
);

   always_comb begin
      o_gnt    = 2'b00;
      o_winner = 1'b0;
      if (i_enable) begin
         case (i_req)
            2'b01: begin
               o_gnt    = 2'b01;
               o_winner = 1'b0;
            end
            2'b10: begin
               o_gnt    = 2'b10;
               o_winner = 1'b1;
            end
            2'b11: begin
               o_winner = ~i_last;
               o_gnt    = i_last ? 2'b01 : 2'b10;
            end
            default: begin
               o_gnt    = 2'b00;
               o_winner = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the core (master 0) and a loader/debug
// master (master 1). Optional perf counters are enabled with ARB_PERF_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   input  logic [DATA_W-1:0] mem_readData,
   output logic              o_dbg_state
`ifdef ARB_PERF_EN
   ,
   output logic [31:0]       perf_gnt0,
   output logic [31:0]       perf_gnt1,
   output logic [31:0]       perf_conflict
`endif
);

   generate
      if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
         $error("mem_port_arbiter: RD_LAT must be in 1..7");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(RD_LAT - 1);

   // Handshake: a master holds req/we/addr/wdata until it sees gnt high in
   // the same cycle; that cycle is the transfer. Read data comes back as a
   // one-cycle rvalid pulse RD_LAT cycles later on the owning master only.

   arb_state_t       r_state;
   arb_state_t       w_next_state;
   logic             r_owner;
   logic             w_next_owner;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_next_cnt;
   logic             r_last;
   logic             w_next_last;

   logic             w_return;
   logic             w_grant_ok;
   logic [1:0]       w_gnt;
   logic             w_winner;
   logic             w_any_gnt;
   logic             w_sel_we;
   logic             w_rv;

   assign w_return   = (r_state == RD_WAIT) && (r_cnt == '0);
   assign w_grant_ok = !rst && ((r_state == IDLE) || w_return);
   assign w_any_gnt  = |w_gnt;
   assign w_sel_we   = w_winner ? m1_we : m0_we;
   assign w_rv       = w_return && !rst;

   rr_pick2 u_pick (
      .i_req    ({m1_req, m0_req}),
      .i_last   (r_last),
      .i_enable (w_grant_ok),
      .o_gnt    (w_gnt),
      .o_winner (w_winner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_cnt   <= '0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next_state;
         r_owner <= w_next_owner;
         r_cnt   <= w_next_cnt;
         r_last  <= w_next_last;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_owner = r_owner;
      w_next_cnt   = r_cnt;
      w_next_last  = r_last;
      if (w_any_gnt) begin
         w_next_last = w_winner;
         if (!w_sel_we) begin
            w_next_state = RD_WAIT;
            w_next_owner = w_winner;
            w_next_cnt   = LOAD_CNT;
         end else begin
            w_next_state = IDLE;
         end
      end else if (w_return) begin
         w_next_state = IDLE;
      end else if (r_state == RD_WAIT) begin
         w_next_cnt = r_cnt - 1'b1;
      end
   end

   always_comb begin
      m0_gnt        = w_gnt[M_CORE];
      m1_gnt        = w_gnt[M_AUX];
      mem_we        = 1'b0;
      mem_address   = '0;
      mem_writeData = '0;
      if (w_any_gnt) begin
         mem_we        = w_sel_we;
         mem_address   = w_winner ? m1_addr  : m0_addr;
         mem_writeData = w_winner ? m1_wdata : m0_wdata;
      end
      m0_rvalid   = w_rv && (r_owner == 1'b0);
      m1_rvalid   = w_rv && (r_owner == 1'b1);
      m0_rdata    = m0_rvalid ? mem_readData : '0;
      m1_rdata    = m1_rvalid ? mem_readData : '0;
      o_dbg_state = r_state;
   end

`ifdef ARB_PERF_EN
   logic [31:0] r_perf_gnt0;
   logic [31:0] r_perf_gnt1;
   logic [31:0] r_perf_conflict;
   logic        w_conflict;

   // Contention cycles plus cycles where a request waits behind a read.
   assign w_conflict = (m0_req && m1_req) ||
                       ((m0_req || m1_req) && (r_state == RD_WAIT) && !w_return);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_gnt0     <= '0;
         r_perf_gnt1     <= '0;
         r_perf_conflict <= '0;
      end else begin
         if (w_gnt[M_CORE]) r_perf_gnt0 <= sat_inc32(r_perf_gnt0);
         if (w_gnt[M_AUX])  r_perf_gnt1 <= sat_inc32(r_perf_gnt1);
         if (w_conflict)    r_perf_conflict <= sat_inc32(r_perf_conflict);
      end
   end

   assign perf_gnt0     = r_perf_gnt0;
   assign perf_gnt1     = r_perf_gnt1;
   assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (RD_LAT 1, 2, 3) share
// one stimulus stream; each scenario checks the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [31:0] mem_readData = '0;

  logic [2:0]  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, dbg_state;
  logic [31:0] m0_rdata [3];
  logic [31:0] m1_rdata [3];
  logic [15:0] mem_address [3];
  logic [31:0] mem_writeData [3];
`ifdef ARB_PERF_EN
  logic [31:0] perf_gnt0 [3];
  logic [31:0] perf_gnt1 [3];
  logic [31:0] perf_conflict [3];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instance g has RD_LAT = g+1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .m0_req        (m0_req),
      .m0_we         (m0_we),
      .m0_addr       (m0_addr),
      .m0_wdata      (m0_wdata),
      .m0_gnt        (m0_gnt[g]),
      .m0_rvalid     (m0_rvalid[g]),
      .m0_rdata      (m0_rdata[g]),
      .m1_req        (m1_req),
      .m1_we         (m1_we),
      .m1_addr       (m1_addr),
      .m1_wdata      (m1_wdata),
      .m1_gnt        (m1_gnt[g]),
      .m1_rvalid     (m1_rvalid[g]),
      .m1_rdata      (m1_rdata[g]),
      .mem_we        (mem_we[g]),
      .mem_address   (mem_address[g]),
      .mem_writeData (mem_writeData[g]),
      .mem_readData  (mem_readData),
      .o_dbg_state   (dbg_state[g])
`ifdef ARB_PERF_EN
      ,
      .perf_gnt0     (perf_gnt0[g]),
      .perf_gnt1     (perf_gnt1[g]),
      .perf_conflict (perf_conflict[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks run 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_reqs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_reqs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset forces gnt low even with a request present.
    idle_reqs();
    rst = 1'b1;
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
    settle();
    chk("rst_m0_gnt", 32'(m0_gnt[0]), 32'd0);
    chk("rst_mem_we", 32'(mem_we[0]), 32'd0);
    chk("rst_mem_addr", 32'(mem_address[0]), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid[0]), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid[0]), 32'd0);

    // Single read, RD_LAT=1.
    tick();
    rst = 1'b0;
    settle();
    chk("rd1_m0_gnt", 32'(m0_gnt[0]), 32'd1);
    chk("rd1_m1_gnt", 32'(m1_gnt[0]), 32'd0);
    chk("rd1_mem_addr", 32'(mem_address[0]), 32'h0010);
    chk("rd1_mem_we", 32'(mem_we[0]), 32'd0);
    tick();
    m0_req = 1'b0;
    mem_readData = 32'hDEADBEEF;
    settle();
    chk("rd1_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
    chk("rd1_m0_rdata", m0_rdata[0], 32'hDEADBEEF);
    chk("rd1_m1_rvalid", 32'(m1_rvalid[0]), 32'd0);
    chk("rd1_m1_rdata", m1_rdata[0], 32'd0);
    tick();
    settle();
    chk("rd1_m0_rvalid_after", 32'(m0_rvalid[0]), 32'd0);
    chk("rd1_m0_rdata_after", m0_rdata[0], 32'd0);

    // Contended writes from reset: m0, m1, m0, m1, m0.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0004; m0_wdata = 32'h11111111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0008; m1_wdata = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("wr_m0_gnt_%0d", i), 32'(m0_gnt[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("wr_m1_gnt_%0d", i), 32'(m1_gnt[0]), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("wr_addr_%0d", i), 32'(mem_address[0]), (i % 2 == 0) ? 32'h0004 : 32'h0008);
      chk($sformatf("wr_data_%0d", i), mem_writeData[0], (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
      chk($sformatf("wr_we_%0d", i), 32'(mem_we[0]), 32'd1);
      tick();
    end
    idle_reqs();
    settle();
    chk("wr_idle_gnt", 32'({m1_gnt[0], m0_gnt[0]}), 32'd0);
    chk("wr_idle_addr", 32'(mem_address[0]), 32'd0);
`ifdef ARB_PERF_EN
    chk("perf_gnt0", perf_gnt0[0], 32'd3);
    chk("perf_gnt1", perf_gnt1[0], 32'd2);
    chk("perf_conflict", perf_conflict[0], 32'd5);
`endif

    // RD_LAT=3: m1 read blocks a pending m0 write until the return cycle.
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
    settle();
    chk("l3_m1_gnt", 32'(m1_gnt[2]), 32'd1);
    chk("l3_addr", 32'(mem_address[2]), 32'h0020);
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0030; m0_wdata = 32'hAAAA5555;
    settle();
    chk("l3_dbg_state", 32'(dbg_state[2]), 32'd1);
    chk("l3_m0_gnt_t1", 32'(m0_gnt[2]), 32'd0);
    chk("l3_mem_we_t1", 32'(mem_we[2]), 32'd0);
    chk("l3_m1_rvalid_t1", 32'(m1_rvalid[2]), 32'd0);
    tick();
    settle();
    chk("l3_m0_gnt_t2", 32'(m0_gnt[2]), 32'd0);
    chk("l3_m1_rvalid_t2", 32'(m1_rvalid[2]), 32'd0);
    tick();
    mem_readData = 32'hCAFEF00D;
    settle();
    chk("l3_m1_rvalid_t3", 32'(m1_rvalid[2]), 32'd1);
    chk("l3_m1_rdata_t3", m1_rdata[2], 32'hCAFEF00D);
    chk("l3_m0_rvalid_t3", 32'(m0_rvalid[2]), 32'd0);
    chk("l3_m0_gnt_t3", 32'(m0_gnt[2]), 32'd1);
    chk("l3_mem_we_t3", 32'(mem_we[2]), 32'd1);
    chk("l3_addr_t3", 32'(mem_address[2]), 32'h0030);
    chk("l3_wdata_t3", mem_writeData[2], 32'hAAAA5555);
    tick();
    m0_req = 1'b0;
    settle();
    chk("l3_m1_rvalid_t4", 32'(m1_rvalid[2]), 32'd0);
    chk("l3_dbg_state_t4", 32'(dbg_state[2]), 32'd0);

    // Back-to-back reads at RD_LAT=1.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0004;
    settle();
    chk("b2b_m0_gnt", 32'(m0_gnt[0]), 32'd1);
    chk("b2b_m1_gnt0", 32'(m1_gnt[0]), 32'd0);
    tick();
    m0_req = 1'b0;
    mem_readData = 32'h00000A0A;
    settle();
    chk("b2b_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
    chk("b2b_m0_rdata", m0_rdata[0], 32'h00000A0A);
    chk("b2b_m1_rvalid0", 32'(m1_rvalid[0]), 32'd0);
    chk("b2b_m1_gnt", 32'(m1_gnt[0]), 32'd1);
    chk("b2b_addr", 32'(mem_address[0]), 32'h0004);
    tick();
    m1_req = 1'b0;
    mem_readData = 32'h0000B0B0;
    settle();
    chk("b2b_m1_rvalid", 32'(m1_rvalid[0]), 32'd1);
    chk("b2b_m1_rdata", m1_rdata[0], 32'h0000B0B0);
    chk("b2b_m0_rvalid1", 32'(m0_rvalid[0]), 32'd0);
    chk("b2b_m0_rdata1", m0_rdata[0], 32'd0);

    // RD_LAT=2: reset mid-read drops the return and restores m0 priority.
    do_reset();
    mem_readData = 32'h12345678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0040;
    settle();
    chk("rr_m0_gnt", 32'(m0_gnt[1]), 32'd1);
    tick();
    m0_req = 1'b0;
    rst = 1'b1;
    settle();
    chk("rr_m0_rvalid_rst", 32'(m0_rvalid[1]), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rr_m0_rvalid_t2", 32'(m0_rvalid[1]), 32'd0);
    chk("rr_m0_rdata_t2", m0_rdata[1], 32'd0);
    chk("rr_dbg_state", 32'(dbg_state[1]), 32'd0);
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0050; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0060; m1_wdata = 32'h1;
    settle();
    chk("rr_m0_rvalid_t3", 32'(m0_rvalid[1]), 32'd0);
    chk("rr_m0_first", 32'(m0_gnt[1]), 32'd1);
    chk("rr_m1_second", 32'(m1_gnt[1]), 32'd0);
    tick();
    idle_reqs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
